// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end: 2-flop sync, debounce and sticky request per road, plus TL_CLK/TICK divider.
// Latency: raw edge to SA/SB is DEB_CYCLES+2 CLK edges; ACK clears a request one edge later.
// Backpressure: none; requests hold until ACK, and a press coinciding with ACK wins.
module traffic_sensor_conditioner #(
    parameter int unsigned DIV        = 20000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic SA_RAW,
    input  logic SB_RAW,
    input  logic ACK_A,
    input  logic ACK_B,
    output logic SA,
    output logic SB,
    output logic TICK,
    output logic TL_CLK
);

    localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
    localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);

    // Index 0 is road A, index 1 is road B.
    logic [1:0]  raw;
    logic [1:0]  ack;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  deb_st;
    logic [1:0]  deb_flip;
    logic [1:0]  deb_rise;
    logic [1:0]  req;
    logic [31:0] deb_cnt [2];
    logic [31:0] dcnt;
    logic        dcnt_wrap;

    assign raw = {SB_RAW, SA_RAW};
    assign ack = {ACK_B, ACK_A};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The debounced state flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_flip = 2'b00;
        deb_rise = 2'b00;
        for (int i = 0; i < 2; i++) begin
            deb_flip[i] = (sync2[i] != deb_st[i]) && (deb_cnt[i] == DEB_LAST);
            deb_rise[i] = deb_flip[i] && sync2[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            deb_st <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb_st[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_flip[i]) begin
                    deb_st[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Set has priority over ACK so a press landing on the acknowledge edge is kept.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            req <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (deb_rise[i]) begin
                    req[i] <= 1'b1;
                end else if (ack[i]) begin
                    req[i] <= 1'b0;
                end
            end
        end
    end

    assign SA = req[0];
    assign SB = req[1];

    assign dcnt_wrap = (dcnt == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            dcnt   <= '0;
            TICK   <= 1'b0;
            TL_CLK <= 1'b0;
        end else if (dcnt_wrap) begin
            dcnt   <= '0;
            TICK   <= 1'b1;
            TL_CLK <= ~TL_CLK;
        end else begin
            dcnt   <= dcnt + 32'd1;
            TICK   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench: table of input/expected-request vectors plus a mid-operation reset sequence.
module tb_traffic_sensor_conditioner;

    logic clk;
    logic rst;
    logic sa_raw;
    logic sb_raw;
    logic ack_a;
    logic ack_b;
    logic sa0, sb0, tick0, tl0;
    logic sa1, sb1, tick1, tl1;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic rst;
        logic sa_raw;
        logic sb_raw;
        logic ack_a;
        logic ack_b;
        logic exp_sa;
        logic exp_sb;
    } vec_t;

    vec_t vecs[$];

    traffic_sensor_conditioner #(.DIV(5), .DEB_CYCLES(4)) u0 (
        .CLK(clk), .RST(rst), .SA_RAW(sa_raw), .SB_RAW(sb_raw),
        .ACK_A(ack_a), .ACK_B(ack_b),
        .SA(sa0), .SB(sb0), .TICK(tick0), .TL_CLK(tl0)
    );

    traffic_sensor_conditioner #(.DIV(1), .DEB_CYCLES(4)) u1 (
        .CLK(clk), .RST(rst), .SA_RAW(sa_raw), .SB_RAW(sb_raw),
        .ACK_A(ack_a), .ACK_B(ack_b),
        .SA(sa1), .SB(sb1), .TICK(tick1), .TL_CLK(tl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic a_raw, input logic b_raw,
                       input logic aa, input logic ab,
                       input logic esa, input logic esb, input int n);
        vec_t v;
        v.rst = r; v.sa_raw = a_raw; v.sb_raw = b_raw;
        v.ack_a = aa; v.ack_b = ab; v.exp_sa = esa; v.exp_sb = esb;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic a_raw, input logic b_raw,
                         input logic aa, input logic ab);
        rst = r; sa_raw = a_raw; sb_raw = b_raw; ack_a = aa; ack_b = ab;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        int k;
        logic e_tick5, e_tl5, e_tick1, e_tl1;

        rst = 1'b0; sa_raw = 1'b0; sb_raw = 1'b0; ack_a = 1'b0; ack_b = 1'b0;

        // Reset with both sensors held, then both requests appear together.
        add(0, 1, 1, 0, 0, 0, 0, 3);
        add(1, 1, 1, 0, 0, 0, 0, 5);
        add(1, 1, 1, 0, 0, 1, 1, 1);
        add(1, 1, 1, 1, 0, 0, 1, 1);
        add(1, 1, 1, 0, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 7);
        // Clean press on A, ACK, holding does not re-request, release.
        add(1, 1, 0, 0, 0, 0, 0, 5);
        add(1, 1, 0, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 0, 1, 0, 2);
        add(1, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 7);
        // Bounce 1,1,0,1...: request 6 edges after the last rising raw edge.
        add(1, 1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 5);
        add(1, 1, 0, 0, 0, 1, 0, 1);
        // Release with request pending leaves it set; ACK then clears it.
        add(1, 0, 0, 0, 0, 1, 0, 7);
        add(1, 0, 0, 1, 0, 0, 0, 1);
        // B: set/ACK collision, re-ACK while held, release and fresh press.
        add(1, 0, 1, 0, 0, 0, 0, 5);
        add(1, 0, 1, 0, 1, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0, 1, 1);
        add(1, 0, 1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0, 8);
        add(1, 0, 0, 0, 0, 0, 0, 6);
        add(1, 0, 1, 0, 0, 0, 0, 5);
        add(1, 0, 1, 0, 0, 0, 1, 1);

        k = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].sa_raw, vecs[i].sb_raw, vecs[i].ack_a, vecs[i].ack_b);
            if (vecs[i].rst) k++;
            else k = 0;
            e_tick5 = vecs[i].rst && (k % 5 == 0);
            e_tl5   = vecs[i].rst && ((k / 5) % 2 == 1);
            e_tick1 = vecs[i].rst;
            e_tl1   = vecs[i].rst && (k % 2 == 1);
            chk("u0.SA", i, sa0, vecs[i].exp_sa);
            chk("u0.SB", i, sb0, vecs[i].exp_sb);
            chk("u0.TICK", i, tick0, e_tick5);
            chk("u0.TL_CLK", i, tl0, e_tl5);
            chk("u1.SA", i, sa1, vecs[i].exp_sa);
            chk("u1.SB", i, sb1, vecs[i].exp_sb);
            chk("u1.TICK", i, tick1, e_tick1);
            chk("u1.TL_CLK", i, tl1, e_tl1);
        end

        // Mid-operation reset with SA=1 and divider count at 3.
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 0, 0, 0);
            chk("pre.SA", i, sa0, (i >= 6));
            chk("pre.TICK", i, tick0, (i == 5));
        end
        chk("pre.TL_CLK", 8, tl0, 1'b1);
        drive(0, 1, 0, 0, 0);
        chk("mid_rst.SA", 0, sa0, 1'b0);
        chk("mid_rst.TL_CLK", 0, tl0, 1'b0);
        chk("mid_rst.TICK", 0, tick0, 1'b0);
        chk("mid_rst.u1.TICK", 0, tick1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            drive(1, 1, 0, 0, 0);
            chk("post.TICK", i, tick0, (i == 5));
            chk("post.TL_CLK", i, tl0, (i >= 5));
            chk("post.SA", i, sa0, (i == 6));
            chk("post.u1.TICK", i, tick1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Upstream front end of the traffic-light controller. Synchronises and debounces the raw car/pedestrian sensor inputs for both roads, turns each clean press into a sticky service request (SA, SB) that holds until the controller acknowledges it, and derives the slow controller clock (TL_CLK) plus a one-cycle TICK enable from the board clock. All logic runs in the CLK domain. The outputs connect directly to the controller's SA, SB and clock inputs.

## Interface
- DIV, 20000000: CLK cycles per TL_CLK half-period and per TICK interval; legal range 1 to 2^32-1.
- DEB_CYCLES, 1000000: consecutive CLK cycles a synchronised input must differ from its debounced state before that state flips; legal range 1 to 2^32-1.
- CLK  input  1  board clock; all flops are rising-edge.
- RST  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- SA_RAW  input  1  raw sensor/button for road A; asynchronous and bouncy.
- SB_RAW  input  1  raw sensor/button for road B; asynchronous and bouncy.
- ACK_A  input  1  controller has served road A; level, sampled on CLK, clears SA.
- ACK_B  input  1  controller has served road B; level, sampled on CLK, clears SB.
- SA  output  1  latched service request for road A.
- SB  output  1  latched service request for road B.
- TICK  output  1  one-CLK-cycle pulse every DIV cycles.
- TL_CLK  output  1  square wave with period 2*DIV CLK cycles; drives the controller clock.

## Operation
- Reset (RST=0 at an edge) sets these to 0: both synchroniser flops per channel, the debounced states STA and STB, both debounce counters, the divider counter, SA, SB, TICK and TL_CLK. Reset mid-operation drops any pending request and any partially counted debounce or divider interval.
- Synchroniser: each raw input passes through two flops (s1 then s2). Only s2 is used downstream.
- Debounce (per channel, 32-bit counter cnt):
  - If s2 equals the debounced state: cnt clears to 0.
  - Else, if cnt is DEB_CYCLES-1: the debounced state takes the s2 value and cnt clears to 0.
  - Else: cnt increments.
  - A bounce back to the old value at any point restarts the count from 0.
- Request latch (per channel). In priority order:
  - set: the debounced state goes 0→1 on this edge; the flop is 1.
  - clear: ACK is 1; the flop is 0.
  - otherwise: hold.
  - Set beats acknowledge on the same edge, so a press coinciding with ACK is not lost.
  - A 1→0 debounced transition (release) never changes the request.
  - Holding the button does not re-set the request after ACK; a fresh 0→1 transition is required.
- Divider (32-bit counter dcnt, range 0..DIV-1):
  - At DIV-1: dcnt wraps to 0, TICK=1 for that cycle, and TL_CLK toggles.
  - Otherwise: dcnt increments and TICK=0.
  - With DIV=1, TICK is constantly 1 and TL_CLK toggles every cycle.
- Channels A and B are fully independent. Simultaneous events on A and B are handled in parallel with no interaction.

## Timing
- Edge numbering: SA_RAW rises and then stays stable before edge 0. The edges go:
  - edge 0: s1=1.
  - edge 1: s2=1.
  - edges 2..DEB_CYCLES: cnt counts 1..DEB_CYCLES-1.
  - edge DEB_CYCLES+1: STA=1 and SA=1 together.
  - Latency from the raw edge to SA is DEB_CYCLES+2 edges.
- ACK_A sampled 1 at edge n gives SA=0 after edge n (one-cycle latency).
- TICK and TL_CLK are registered outputs, glitch-free.
- After reset release:
  - First TICK is high during the cycle following the DIV-th edge at which RST=1.
  - TL_CLK first rises at that same edge.
- Every output is a flop; none is combinational from an input.

## Test plan
- Reset: hold RST=0 for 3 cycles with SA_RAW=SB_RAW=1 → SA=SB=TICK=TL_CLK=0 throughout; no request appears until DEB_CYCLES+2 edges after RST rises.
- Clean press (DEB_CYCLES=4): raise SA_RAW before edge 0 → SA=1 exactly after edge 5. Pulse ACK_A for 1 cycle → SA=0 on the next edge. SB stays 0 throughout.
- Bounce (DEB_CYCLES=4): SA_RAW pattern 1,1,0,1,1,1,1,1 over successive cycles → SA rises only 6 edges after the last 0→1 transition, never earlier.
- Set/ack collision: assert ACK_B on the same edge that STB goes 0→1 → SB=1 afterwards. Hold SB_RAW=1 and pulse ACK_B again → SB=0 and stays 0 until SB_RAW is released for ≥4 cycles and pressed again.
- Divider (DIV=5): over 40 cycles after reset → TICK high exactly 1 cycle in 5; TL_CLK period is 10 cycles with 50% duty. With DIV=1 → TICK constant 1 and TL_CLK toggles every edge.
- Reset mid-operation: with SA=1 and dcnt=3 (DIV=5), pulse RST=0 for 1 cycle → SA=0, TL_CLK=0, and the next TICK is 5 edges after RST returns to 1.
